// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG pixel output stage: FSM states, level-shift
// and clamp constants, and the pixel-pair record carried through the FIFO.
package jpeg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } pixoutState_t;

  localparam int LEVEL_SHIFT = 128;
  localparam int PIX_MIN     = 0;
  localparam int PIX_MAX     = 255;

  localparam logic [4:0] BLOCK_LAST_ADDR = 5'h1F;

  // One buffered output pair plus the block address it came from.
  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] pixA;
    logic [7:0] pixB;
  } pixPair_t;

endpackage

// File: rtl/jpeg_pixout_fifo.sv
// Small synchronous FIFO for pixel pairs. DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module jpeg_pixout_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign count   = wrPtr - rdPtr;
  assign empty   = (wrPtr == rdPtr);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr[AW-1:0]];

  // Storage write port.
  // NOTE: the storage array has no reset; empty gates every use of stale entries.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

  // Read/write pointer update; reset and flush share the rst input.
  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/jpeg_idct_pixout.sv
// iDCT pixel output stage: reads 32-word blocks (two samples per word) from
// the upstream bank buffer, scales, level-shifts and clamps each sample to an
// 8-bit pixel, and presents pairs through a small FIFO with ready/enable flow
// control. Optional rounding is enabled by defining JPEG_IDCT_PIXOUT_ROUND_EN.
module jpeg_idct_pixout
  import jpeg_pkg::*;
#(
  parameter int SHIFT      = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataInit,
  input  logic        DataInEnable,
  output logic        DataInRead,
  output logic [4:0]  DataInAddress,
  input  logic [15:0] DataInA,
  input  logic [15:0] DataInB,
  output logic        OutEnable,
  input  logic        OutReady,
  output logic [7:0]  OutPixelA,
  output logic [7:0]  OutPixelB,
  output logic [4:0]  OutAddress,
  output logic        OutBlockEnd
);

`ifdef JPEG_IDCT_PIXOUT_ROUND_EN
  localparam logic signed [16:0] ROUND = 17'(1 << (SHIFT - 1));
`else
  localparam logic signed [16:0] ROUND = '0;
`endif

  localparam int PAIR_W = $bits(pixPair_t);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W  = CNT_W + 1;

  // Scale one signed sample to a clamped unsigned pixel.
  function automatic logic [7:0] toPixel(input logic signed [15:0] x);
    logic signed [16:0] sum;
    logic signed [16:0] scaled;
    logic signed [16:0] level;
    sum    = $signed({x[15], x}) + ROUND;
    scaled = sum >>> SHIFT;
    level  = scaled + 17'(LEVEL_SHIFT);
    if (level < 17'(PIX_MIN))      return 8'(PIX_MIN);
    else if (level > 17'(PIX_MAX)) return 8'(PIX_MAX);
    else                           return level[7:0];
  endfunction

  pixoutState_t        state;
  logic [4:0]          addrCnt;
  logic                inFlight;
  logic [4:0]          inFlightAddr;
  logic                fifoRst;
  logic                fifoPush;
  logic                fifoFull;
  logic                fifoEmpty;
  logic [CNT_W-1:0]    fifoCount;
  logic [PAIR_W-1:0]   headBits;
  pixPair_t            headPair;
  pixPair_t            pushPair;
  logic                popNow;
  logic [CRD_W-1:0]    pending;
  logic                canRead;

  // Reads are throttled so buffered plus in-flight pairs never exceed the FIFO.
  assign popNow  = OutEnable && OutReady;
  assign pending = CRD_W'(fifoCount) + CRD_W'(inFlight) - CRD_W'(popNow);
  assign canRead = !fifoFull && (pending < CRD_W'(FIFO_DEPTH));

  // In DRAIN a waiting next block may start immediately, keeping one pair per cycle.
  assign DataInRead    = !DataInit && canRead &&
                         ((state == READ) || ((state == DRAIN) && DataInEnable));
  assign DataInAddress = addrCnt;

  // Block read sequencing: address counter and IDLE/READ/DRAIN control.
  always_ff @(posedge clk) begin
    if (rst || DataInit) begin
      state   <= IDLE;
      addrCnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (DataInEnable) state <= READ;
        READ: begin
          if (DataInRead) begin
            addrCnt <= addrCnt + 1'b1;
            if (addrCnt == BLOCK_LAST_ADDR) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (DataInRead) begin
            addrCnt <= addrCnt + 1'b1;
            state   <= READ;
          end else if (fifoEmpty && !DataInEnable) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Remember which address the upstream buffer is returning this cycle.
  always_ff @(posedge clk) begin
    if (rst || DataInit) begin
      inFlight     <= 1'b0;
      inFlightAddr <= '0;
    end else begin
      inFlight     <= DataInRead;
      inFlightAddr <= addrCnt;
    end
  end

  // Returned samples are converted and pushed in the capture cycle.
  assign pushPair = '{addr: inFlightAddr, pixA: toPixel(DataInA), pixB: toPixel(DataInB)};
  assign fifoPush = inFlight && !DataInit;
  assign fifoRst  = rst || DataInit;

  jpeg_pixout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAIR_W)
  ) uFifo (
    .clk      (clk),
    .rst      (fifoRst),
    .push     (fifoPush),
    .pushData (pushPair),
    .pop      (popNow),
    .popData  (headBits),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Head of the FIFO is presented directly; fields read zero while empty.
  assign headPair    = pixPair_t'(headBits);
  assign OutEnable   = !fifoEmpty;
  assign OutPixelA   = fifoEmpty ? '0 : headPair.pixA;
  assign OutPixelB   = fifoEmpty ? '0 : headPair.pixB;
  assign OutAddress  = fifoEmpty ? '0 : headPair.addr;
  assign OutBlockEnd = !fifoEmpty && (headPair.addr == BLOCK_LAST_ADDR);

endmodule

// File: tb/tb_jpeg_idct_pixout.sv
// Self-checking bench for jpeg_idct_pixout: randomized samples and OutReady
// patterns against an arithmetic reference of the pixel mapping and the
// expected in-order pair stream.
module tb_jpeg_idct_pixout;

  localparam int SHIFT      = 3;
  localparam int FIFO_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        DataInit;
  logic        DataInEnable;
  logic        DataInRead;
  logic [4:0]  DataInAddress;
  logic [15:0] DataInA;
  logic [15:0] DataInB;
  logic        OutEnable;
  logic        OutReady;
  logic [7:0]  OutPixelA;
  logic [7:0]  OutPixelB;
  logic [4:0]  OutAddress;
  logic        OutBlockEnd;

  jpeg_idct_pixout #(
    .SHIFT      (SHIFT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .DataInit      (DataInit),
    .DataInEnable  (DataInEnable),
    .DataInRead    (DataInRead),
    .DataInAddress (DataInAddress),
    .DataInA       (DataInA),
    .DataInB       (DataInB),
    .OutEnable     (OutEnable),
    .OutReady      (OutReady),
    .OutPixelA     (OutPixelA),
    .OutPixelB     (OutPixelB),
    .OutAddress    (OutAddress),
    .OutBlockEnd   (OutBlockEnd)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Upstream image data and model of the expected output stream.
  logic signed [15:0] srcA [64];
  logic signed [15:0] srcB [64];
  int  k;              // pairs accepted so far
  int  issued;         // reads issued so far
  int  pushed, popped; // pairs entered / left the output buffer
  bit  pendValid;
  int  pendIdx;
  int  blocksAvail, blocksStarted;
  int  readyMode;
  int  cyc;
  bit  rstReq;
  bit  stallPrev;
  logic [7:0] prevA, prevB;
  logic [4:0] prevAddr;
  logic       prevEnd;
  bit  initArmed, initFired;
  int  firstReadCyc, firstOeCyc;
  int  run, maxRun;
  bit  directedOn;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: floor((x + R) / 2^SHIFT) + 128, clamped to 0..255.
  function automatic int refPixel(input int x);
    int d, v, q, p;
    d = 1 << SHIFT;
`ifdef JPEG_IDCT_PIXOUT_ROUND_EN
    v = x + d / 2;
`else
    v = x;
`endif
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    p = q + 128;
    if (p < 0)   p = 0;
    if (p > 255) p = 255;
    return p;
  endfunction

  task automatic clearModel();
    k = 0; issued = 0; pushed = 0; popped = 0;
    pendValid = 0; pendIdx = 0;
    blocksAvail = 0; blocksStarted = 0;
    firstReadCyc = -1; firstOeCyc = -1;
    run = 0; maxRun = 0;
    stallPrev = 0; directedOn = 0;
    initArmed = 0; initFired = 0;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        srcA[i] = 16'($urandom_range(0, 2303) - 1152);
        srcB[i] = 16'($urandom_range(0, 2303) - 1152);
      end else begin
        srcA[i] = 16'($urandom);
        srcB[i] = 16'($urandom);
      end
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then sample and check.
  task automatic step();
    bit rdNow, popNow;
    int occ;
    @(negedge clk);
    cyc++;
    rst = rstReq;
    if (pendValid) begin
      DataInA = srcA[pendIdx];
      DataInB = srcB[pendIdx];
    end else begin
      DataInA = 16'($urandom);
      DataInB = 16'($urandom);
    end
    case (readyMode)
      0:       OutReady = 1'b1;
      1:       OutReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       OutReady = 1'($urandom_range(0, 1));
      default: OutReady = 1'b0;
    endcase
    DataInEnable = (blocksStarted < blocksAvail);
    DataInit = 1'b0;
    #1;
    if (!rst && initArmed && DataInRead && DataInAddress == 5'd10) begin
      DataInit  = 1'b1;
      initArmed = 0;
      initFired = 1;
      #1;
    end
    popNow = OutEnable && OutReady;
    rdNow  = DataInRead;
    occ    = pushed - popped;
    if (!rst) begin
      if (stallPrev) begin
        checkVal("stallHoldEn", OutEnable, 1);
        checkVal("stallHoldAddr", OutAddress, prevAddr);
        checkVal("stallHoldA", OutPixelA, prevA);
        checkVal("stallHoldB", OutPixelB, prevB);
        checkVal("stallHoldEnd", OutBlockEnd, prevEnd);
      end
      if (occ >= FIFO_DEPTH) checkVal("readWhenFull", rdNow, 0);
      if (rdNow) begin
        checkVal("rdAddr", DataInAddress, issued % 32);
        if (firstReadCyc < 0) firstReadCyc = cyc;
        if ((issued % 32) == 0) blocksStarted++;
      end
      if (OutEnable) begin
        if (firstOeCyc < 0) firstOeCyc = cyc;
        run++;
        if (run > maxRun) maxRun = run;
      end else begin
        run = 0;
      end
      if (popNow) begin
        if (k < 64) begin
          checkVal("outAddr", OutAddress, k % 32);
          checkVal("outPixA", OutPixelA, refPixel(int'(srcA[k])));
          checkVal("outPixB", OutPixelB, refPixel(int'(srcB[k])));
          checkVal("blockEnd", OutBlockEnd, ((k % 32) == 31));
        end else begin
          checkVal("extraPair", k, 63);
        end
        if (directedOn && k == 3) begin
          checkVal("clamp1024", OutPixelA, 255);
          checkVal("clampNeg1100", OutPixelB, 0);
        end
        if (directedOn && k == 4) begin
`ifdef JPEG_IDCT_PIXOUT_ROUND_EN
          checkVal("round12", OutPixelA, 130);
`else
          checkVal("trunc12", OutPixelA, 129);
`endif
          checkVal("clamp1023", OutPixelB, 255);
        end
        k++;
      end
    end
    stallPrev = !rst && OutEnable && !OutReady && !DataInit;
    prevA = OutPixelA; prevB = OutPixelB; prevAddr = OutAddress; prevEnd = OutBlockEnd;
    if (rst || DataInit) begin
      pendValid = 0; pushed = 0; popped = 0; run = 0;
    end else begin
      if (popNow) popped++;
      if (pendValid) pushed++;
      pendValid = rdNow;
      pendIdx   = issued;
      if (rdNow) issued++;
    end
  endtask

  task automatic checkResetOuts(input string tag);
    checkVal({tag, ".DataInRead"}, DataInRead, 0);
    checkVal({tag, ".DataInAddress"}, DataInAddress, 0);
    checkVal({tag, ".OutEnable"}, OutEnable, 0);
    checkVal({tag, ".OutPixelA"}, OutPixelA, 0);
    checkVal({tag, ".OutPixelB"}, OutPixelB, 0);
    checkVal({tag, ".OutAddress"}, OutAddress, 0);
    checkVal({tag, ".OutBlockEnd"}, OutBlockEnd, 0);
  endtask

  // Run until n pairs are accepted (bounded), then idle and confirm no extras.
  task automatic runPairs(input int n, input int budget);
    int t;
    t = 0;
    while (k < n && t < budget) begin
      step();
      t++;
    end
    checkVal("pairCount", k, n);
    readyMode = 0;
    repeat (4) step();
    checkVal("noExtraPairs", k, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clk = 0; rst = 1; DataInit = 0; DataInEnable = 0; OutReady = 0;
    DataInA = 0; DataInB = 0;
    vectors = 0; miscompares = 0; cyc = 0;
    rstReq = 1; readyMode = 3;
    clearModel();

    // Power-on reset.
    repeat (3) step();
    rstReq = 0;
    step();
    checkResetOuts("por");

    // All-zero block, always ready: 128/128 pairs, latency 2, unbroken run.
    clearModel();
    for (int i = 0; i < 64; i++) begin srcA[i] = 0; srcB[i] = 0; end
    blocksAvail = 1; readyMode = 0;
    runPairs(32, 200);
    checkVal("firstOeLatency", firstOeCyc - firstReadCyc, 2);
    checkVal("zeroBlockRun", maxRun, 32);

    // Clamp and rounding boundaries.
    clearModel();
    fillRandom();
    srcA[3] = 16'sd1024; srcB[3] = -16'sd1100;
    srcA[4] = 16'sd12;   srcB[4] = 16'sd1023;
    srcA[5] = 16'sh7FFF; srcB[5] = 16'sh8000;
    directedOn = 1; blocksAvail = 1; readyMode = 0;
    runPairs(32, 200);

    // OutReady pattern 1,0,0,1 over a full block.
    clearModel();
    fillRandom();
    blocksAvail = 1; readyMode = 1;
    runPairs(32, 600);

    // Random OutReady over a full block.
    clearModel();
    fillRandom();
    blocksAvail = 1; readyMode = 2;
    runPairs(32, 600);

    // Two blocks back-to-back with OutReady held high.
    clearModel();
    fillRandom();
    blocksAvail = 2; readyMode = 0;
    runPairs(64, 400);
    checkVal("b2bRun", maxRun, 64);

    // DataInit while reading address 10, then a fresh block from address 0.
    clearModel();
    fillRandom();
    blocksAvail = 1; readyMode = 0; initArmed = 1;
    for (int t = 0; t < 100 && !initFired; t++) step();
    checkVal("initFired", initFired, 1);
    step();
    checkVal("initOutEnable", OutEnable, 0);
    checkVal("initDataInRead", DataInRead, 0);
    checkVal("initAddress", DataInAddress, 0);
    step();
    checkVal("initIdle", DataInRead, 0);
    clearModel();
    fillRandom();
    blocksAvail = 1; readyMode = 2;
    runPairs(32, 600);

    // Reset while the output buffer holds two pairs.
    clearModel();
    fillRandom();
    blocksAvail = 1; readyMode = 3;
    repeat (5) step();
    checkVal("bufferedBeforeRst", OutEnable, 1);
    checkVal("readBlockedWhileFull", DataInRead, 0);
    rstReq = 1;
    step();
    rstReq = 0;
    readyMode = 0;
    step();
    checkResetOuts("rstFull");
    for (int t = 0; t < 6; t++) begin
      step();
      checkVal("quietAfterRst", OutEnable, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
